// File: rtl/ps2_keymap_decoder.sv
// PS/2 scancode decoder: tracks make/break/extended prefixes and held keys,
// and drives a one-hot game command word with event and error pulses.
module ps2_keymap_decoder #(
  parameter bit HOLD_MODE      = 1'b1,
  parameter bit ENABLE_ARROWS  = 1'b1,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int TO_W           = 16
) (
  input  logic       in_clk,
  input  logic       in_reset_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic [6:0] out_data,
  output logic [3:0] out_held,
  output logic       out_event,
  output logic       out_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BREAK,
    S_EXT,
    S_EXT_BREAK
  } state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [6:0] CMD_STOP  = 7'b0000001;
  localparam logic [6:0] CMD_PAUSE = 7'b0000010;
  localparam logic [6:0] CMD_RESET = 7'b0000100;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [TO_W-1:0] r_to_cnt;
  logic [6:0]      r_data;
  logic [3:0]      r_held;
  logic            r_event;
  logic            r_err;

  logic       w_is_f0;
  logic       w_is_e0;
  logic       w_timeout;
  logic       w_make;
  logic       w_brk;
  logic       w_ext;
  logic       w_illegal;
  logic [3:0] w_dir;
  logic       w_rst_key;
  logic       w_pause_key;
  logic       w_drop;
  logic [6:0] w_data_nxt;
  logic [3:0] w_held_nxt;
  logic       w_err_nxt;

  assign w_is_f0   = (in_data == 8'hF0);
  assign w_is_e0   = (in_data == 8'hE0);
  assign w_timeout = (r_state != S_IDLE) && !in_valid
                     && (r_to_cnt == TO_LAST);
  assign w_drop    = w_ext && !ENABLE_ARROWS;

  // Highest-priority held direction: up > down > left > right.
  function automatic logic [6:0] fallback(input logic [3:0] held);
    logic [6:0] cmd;
    cmd = CMD_STOP;
    if (held[3])      cmd = 7'b1000000;
    else if (held[2]) cmd = 7'b0100000;
    else if (held[1]) cmd = 7'b0010000;
    else if (held[0]) cmd = 7'b0001000;
    return cmd;
  endfunction

  always_ff @(posedge in_clk or negedge in_reset_n) begin
    if (!in_reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_timeout) begin
      w_state_nxt = S_IDLE;
    end else if (in_valid) begin
      unique case (r_state)
        S_IDLE: begin
          if (w_is_f0)      w_state_nxt = S_BREAK;
          else if (w_is_e0) w_state_nxt = S_EXT;
          else              w_state_nxt = S_IDLE;
        end
        S_EXT: begin
          if (w_is_f0) w_state_nxt = S_EXT_BREAK;
          else         w_state_nxt = S_IDLE;
        end
        S_BREAK:     w_state_nxt = S_IDLE;
        S_EXT_BREAK: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_make    = 1'b0;
    w_brk     = 1'b0;
    w_ext     = 1'b0;
    w_illegal = 1'b0;
    if (in_valid) begin
      unique case (r_state)
        S_IDLE: begin
          w_make = !w_is_f0 && !w_is_e0;
        end
        S_BREAK: begin
          w_illegal = w_is_f0 || w_is_e0;
          w_brk     = !(w_is_f0 || w_is_e0);
        end
        S_EXT: begin
          w_illegal = w_is_e0;
          w_make    = !w_is_f0 && !w_is_e0;
          w_ext     = 1'b1;
        end
        S_EXT_BREAK: begin
          w_illegal = w_is_f0 || w_is_e0;
          w_brk     = !(w_is_f0 || w_is_e0);
          w_ext     = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    w_dir       = 4'b0000;
    w_rst_key   = 1'b0;
    w_pause_key = 1'b0;
    if (w_ext) begin
      if (ENABLE_ARROWS) begin
        case (in_data)
          8'h75:   w_dir = 4'b1000;
          8'h72:   w_dir = 4'b0100;
          8'h6B:   w_dir = 4'b0010;
          8'h74:   w_dir = 4'b0001;
          default: w_dir = 4'b0000;
        endcase
      end
    end else begin
      case (in_data)
        8'h1D:   w_dir       = 4'b1000;
        8'h1B:   w_dir       = 4'b0100;
        8'h1C:   w_dir       = 4'b0010;
        8'h23:   w_dir       = 4'b0001;
        8'h2D:   w_rst_key   = 1'b1;
        8'h4D:   w_pause_key = 1'b1;
        default: w_dir       = 4'b0000;
      endcase
    end
  end

  always_comb begin
    w_data_nxt = r_data;
    w_held_nxt = r_held;
    w_err_nxt  = w_illegal || w_timeout;
    if (w_make && !w_drop) begin
      if (|w_dir) begin
        w_held_nxt = r_held | w_dir;
        w_data_nxt = {w_dir, 3'b000};
      end else if (w_rst_key) begin
        w_data_nxt = CMD_RESET;
      end else if (w_pause_key) begin
        w_data_nxt = CMD_PAUSE;
      end else if (!HOLD_MODE) begin
        w_data_nxt = CMD_STOP;
      end
    end else if (w_brk && !w_drop && (|w_dir)) begin
      w_held_nxt = r_held & ~w_dir;
      if (HOLD_MODE && (r_data == {w_dir, 3'b000})) begin
        w_data_nxt = fallback(r_held & ~w_dir);
      end
    end
  end

  always_ff @(posedge in_clk or negedge in_reset_n) begin
    if (!in_reset_n) begin
      r_data   <= CMD_STOP;
      r_held   <= 4'b0000;
      r_event  <= 1'b0;
      r_err    <= 1'b0;
      r_to_cnt <= '0;
    end else begin
      r_data  <= w_data_nxt;
      r_held  <= w_held_nxt;
      r_event <= (w_data_nxt != r_data);
      r_err   <= w_err_nxt;
      if (in_valid || (r_state == S_IDLE) || w_timeout) begin
        r_to_cnt <= '0;
      end else begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end
    end
  end

  assign out_data  = r_data;
  assign out_held  = r_held;
  assign out_event = r_event;
  assign out_err   = r_err;

endmodule

// File: tb/tb_ps2_keymap_decoder.sv
// Directed bench for ps2_keymap_decoder: hold mode, arrows off,
// and legacy latch variants driven from one shared byte stream.
module tb_ps2_keymap_decoder;

  logic       clk;
  logic       rst_n;
  logic [7:0] din;
  logic       vld;

  logic [6:0] d1, d2, d3;
  logic [3:0] h1, h2, h3;
  logic       e1, e2, e3;
  logic       r1, r2, r3;

  int checks;
  int errors;
  int ev1_c, er1_c, ev2_c, er2_c, excl_c;
  int b1, b2, b3;

  ps2_keymap_decoder #(
    .HOLD_MODE(1'b1), .ENABLE_ARROWS(1'b1),
    .TIMEOUT_CYCLES(16), .TO_W(5)
  ) u_hold (
    .in_clk(clk), .in_reset_n(rst_n),
    .in_data(din), .in_valid(vld),
    .out_data(d1), .out_held(h1),
    .out_event(e1), .out_err(r1)
  );

  ps2_keymap_decoder #(
    .HOLD_MODE(1'b1), .ENABLE_ARROWS(1'b0),
    .TIMEOUT_CYCLES(16), .TO_W(5)
  ) u_noarr (
    .in_clk(clk), .in_reset_n(rst_n),
    .in_data(din), .in_valid(vld),
    .out_data(d2), .out_held(h2),
    .out_event(e2), .out_err(r2)
  );

  ps2_keymap_decoder #(
    .HOLD_MODE(1'b0), .ENABLE_ARROWS(1'b1),
    .TIMEOUT_CYCLES(16), .TO_W(5)
  ) u_latch (
    .in_clk(clk), .in_reset_n(rst_n),
    .in_data(din), .in_valid(vld),
    .out_data(d3), .out_held(h3),
    .out_event(e3), .out_err(r3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    ev1_c  <= ev1_c + int'(e1);
    er1_c  <= er1_c + int'(r1);
    ev2_c  <= ev2_c + int'(e2);
    er2_c  <= er2_c + int'(r2);
    excl_c <= excl_c + int'((e1 && r1) || (e2 && r2) || (e3 && r3));
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    din = b;
    vld = 1'b1;
    @(negedge clk);
    vld = 1'b0;
  endtask

  task automatic do_reset();
    vld   = 1'b0;
    din   = 8'h00;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b1;
    vld    = 1'b0;
    din    = 8'h00;
    @(negedge clk);

    // 1: reset state, make and break of up
    do_reset();
    chk("rst_data", d1, 7'h01);
    chk("rst_held", h1, 4'h0);
    chk("rst_event", e1, 0);
    chk("rst_err", r1, 0);
    send(8'h1D);
    chk("up_make_data", d1, 7'h40);
    chk("up_make_held", h1, 4'h8);
    chk("up_make_event", e1, 1);
    send(8'hF0);
    chk("f0_no_event", e1, 0);
    send(8'h1D);
    chk("up_brk_data", d1, 7'h01);
    chk("up_brk_held", h1, 4'h0);
    chk("up_brk_event", e1, 1);

    // 2: fallback to still-held up
    do_reset();
    send(8'h1D);
    send(8'h1C);
    chk("left_data", d1, 7'h10);
    chk("left_held", h1, 4'hA);
    send(8'hF0);
    send(8'h1C);
    chk("fallback_data", d1, 7'h40);
    chk("fallback_held", h1, 4'h8);
    chk("fallback_event", e1, 1);

    // 3: typematic repeat
    do_reset();
    b1 = ev1_c;
    for (int i = 0; i < 5; i++) begin
      send(8'h23);
      chk($sformatf("typematic_held%0d", i), h1, 4'h1);
    end
    @(negedge clk);
    chk("typematic_data", d1, 7'h08);
    chk("typematic_events", ev1_c - b1, 1);

    // 4: arrow aliases, and arrows disabled
    do_reset();
    b1 = ev1_c;
    b2 = ev2_c;
    b3 = er2_c;
    send(8'hE0);
    send(8'h75);
    chk("arrow_up_data", d1, 7'h40);
    chk("arrow_up_held", h1, 4'h8);
    chk("noarr_data", d2, 7'h01);
    chk("noarr_held", h2, 4'h0);
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
    chk("arrow_brk_data", d1, 7'h01);
    chk("arrow_brk_held", h1, 4'h0);
    @(negedge clk);
    chk("arrow_events", ev1_c - b1, 2);
    chk("noarr_events", ev2_c - b2, 0);
    chk("noarr_errs", er2_c - b3, 0);
    chk("noarr_data_end", d2, 7'h01);

    // 5: prefix timeout
    do_reset();
    b1 = er1_c;
    send(8'hF0);
    repeat (15) @(negedge clk);
    chk("to_early", r1, 0);
    @(negedge clk);
    chk("to_err", r1, 1);
    chk("to_data", d1, 7'h01);
    @(negedge clk);
    chk("to_err_pulse", r1, 0);
    chk("to_err_count", er1_c - b1, 1);
    send(8'h1B);
    chk("to_then_make", d1, 7'h20);
    chk("to_then_held", h1, 4'h4);

    do_reset();
    send(8'hF0);
    repeat (15) @(negedge clk);
    send(8'h1B);
    chk("to_edge_noerr", r1, 0);
    chk("to_edge_brk", d1, 7'h01);
    send(8'h1B);
    chk("to_edge_make", d1, 7'h20);

    // reset mid-sequence aborts the break prefix
    do_reset();
    send(8'h1D);
    send(8'hF0);
    do_reset();
    chk("midrst_data", d1, 7'h01);
    send(8'h1D);
    chk("midrst_make", d1, 7'h40);
    chk("midrst_held", h1, 4'h8);

    // 6: illegal prefixes
    do_reset();
    send(8'h1D);
    send(8'hF0);
    send(8'hF0);
    chk("f0f0_err", r1, 1);
    chk("f0f0_data", d1, 7'h40);
    chk("f0f0_held", h1, 4'h8);
    send(8'hE0);
    send(8'hE0);
    chk("e0e0_err", r1, 1);
    chk("e0e0_data", d1, 7'h40);
    send(8'h1D);
    chk("after_illegal_ev", e1, 0);
    chk("after_illegal_err", r1, 0);

    // legacy latch variant
    do_reset();
    send(8'h4D);
    chk("latch_pause", d3, 7'h02);
    send(8'h55);
    chk("latch_unknown", d3, 7'h01);
    chk("hold_unknown", d1, 7'h02);
    send(8'h4D);
    send(8'hF0);
    send(8'h4D);
    chk("latch_pbrk", d3, 7'h02);
    chk("latch_pbrk_ev", e3, 0);
    send(8'h1D);
    send(8'hF0);
    send(8'h1D);
    chk("latch_brk_data", d3, 7'h40);
    chk("latch_brk_held", h3, 4'h0);
    send(8'hE1);
    chk("latch_e1", d3, 7'h01);
    chk("hold_e1", d1, 7'h01);

    @(negedge clk);
    chk("event_err_exclusive", excl_c, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
